sys_bus_bridge: RTL

//  CPU-side initiator of the peripheral bus: decodes CPU addresses into device slots and drives ADD_I/WE_I/DAT_I

---
 rtl/sys_bus_bridge.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: CPU-side initiator of the peripheral bus.
//  - Decodes CPU addresses into NDEV device slots plus a local register window.
//  - Posts writes through a WBUF_DEPTH-entry FIFO that drains one entry per edge.
//  - Runs reads through a two-state IDLE/RD sequence and returns device data
//    one cycle after the address is presented.
//  - Latches device IRQ pulses into PEND and drives HWInt = {err, pend & mask}.
// Optional feature: define BRIDGE_ERR_EN to capture miss addresses in ERR_ADDR
// and raise HWInt[5].
module sys_bus_bridge #(
  parameter int          NDEV       = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
  parameter logic [31:0] LOCAL_BASE = 32'h0000_7F40,
  parameter int          WBUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        PrAddr,
  input  logic [31:0]        PrWD,
  input  logic               PrWE,
  input  logic               PrRE,
  output logic               PrStall,
  output logic [31:0]        PrRD,
  output logic               PrRdValid,
  output logic [5:0]         HWInt,
  output logic [3:0]         DEV_ADD,
  output logic [NDEV-1:0]    DEV_WE,
  output logic [31:0]        DEV_DAT,
  input  logic [32*NDEV-1:0] DEV_RD,
  input  logic [NDEV-1:0]    DEV_IRQ
);
  localparam int          AW      = $clog2(WBUF_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [1:0]  K_DEV   = 2'd0, K_LOC = 2'd1, K_MISS = 2'd2;
  localparam logic [0:0]  S_IDLE  = 1'b0, S_RD  = 1'b1;
  localparam logic [1:0]  R_PEND  = 2'd0, R_MASK = 2'd1, R_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  slot;
    logic [3:0]  off;
    logic [31:0] data;
  } wr_ent_t;

  logic [1:0]      req_kind;
  logic [2:0]      req_slot;
  wr_ent_t         wbuf [WBUF_DEPTH];
  wr_ent_t         head;
  logic [AW:0]     wptr, rptr;
  logic            empty, full, push, pop, rd_acc, loc_wr;
  logic [0:0]      state;
  logic [1:0]      rd_kind, rd_reg;
  logic [2:0]      rd_slot;
  logic [31:0]     dev_sel, loc_sel, rd_data;
  logic [NDEV-1:0] pend, pend_clr;
  logic [5:0]      mask;
  logic            err;
  logic [31:0]     err_addr;

  // Address decode: device slot window, local register window, or miss
  always_comb begin
    req_slot = 3'((PrAddr - DEV_BASE) >> 4);
    if (PrAddr >= DEV_BASE && PrAddr < DEV_BASE + 32'(16 * NDEV))
      req_kind = K_DEV;
    else if (PrAddr >= LOCAL_BASE && PrAddr < LOCAL_BASE + 32'd16)
      req_kind = K_LOC;
    else
      req_kind = K_MISS;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = wbuf[rptr[AW-1:0]];
  assign pop   = !empty;

  // Stall: RD blocks everything; writes wait on full, reads wait for drain
  always_comb begin
    PrStall = 1'b0;
    if (state == S_RD)  PrStall = 1'b1;
    else if (PrWE)      PrStall = full;
    else if (PrRE)      PrStall = !empty;
  end

  assign push   = PrWE && !PrStall;
  assign rd_acc = PrRE && !PrWE && !PrStall;
  assign loc_wr = pop && (head.kind == K_LOC);
  assign pend_clr = (loc_wr && head.off[3:2] == R_PEND) ? head.data[NDEV-1:0] : '0;

  // FIFO storage; pointers alone say which entries are live, so no reset
  always_ff @(posedge clk)
    if (push) wbuf[wptr[AW-1:0]] <= '{kind: req_kind, slot: req_slot, off: PrAddr[3:0], data: PrWD};

  // FIFO pointers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end

  // Read data select for the access launched on the previous edge
  always_comb begin
    dev_sel = '0;
    for (int i = 0; i < NDEV; i++)
      if (rd_slot == 3'(i)) dev_sel = DEV_RD[32*i +: 32];
    case (rd_reg)
      R_PEND:  loc_sel = 32'(pend);
      R_MASK:  loc_sel = 32'(mask);
      R_ERR:   loc_sel = err_addr;
      default: loc_sel = '0;
    endcase
    case (rd_kind)
      K_DEV:   rd_data = dev_sel;
      K_LOC:   rd_data = loc_sel;
      default: rd_data = '0;
    endcase
  end

  // Bus sequencing: pop one posted write per edge, or launch/complete a read
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= S_IDLE;
      rd_kind   <= K_MISS;
      rd_slot   <= '0;
      rd_reg    <= '0;
      PrRD      <= '0;
      PrRdValid <= 1'b0;
      DEV_ADD   <= '0;
      DEV_WE    <= '0;
      DEV_DAT   <= '0;
    end else begin
      PrRdValid <= 1'b0;
      DEV_WE    <= '0;
      if (pop) begin
        DEV_ADD <= head.off;
        DEV_DAT <= head.data;
        if (head.kind == K_DEV) DEV_WE <= NDEV'(1) << head.slot;
      end else if (rd_acc) begin
        DEV_ADD <= PrAddr[3:0];
        rd_kind <= req_kind;
        rd_slot <= req_slot;
        rd_reg  <= PrAddr[3:2];
        state   <= S_RD;
      end
      if (state == S_RD) begin
        PrRD      <= rd_data;
        PrRdValid <= 1'b1;
        state     <= S_IDLE;
      end
    end

  // Pending IRQs (a new pulse beats a same-edge W1C) and the mask register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend <= '0;
      mask <= '1;
    end else begin
      pend <= (pend & ~pend_clr) | DEV_IRQ;
      if (loc_wr && head.off[3:2] == R_MASK) mask <= head.data[5:0];
    end

`ifdef BRIDGE_ERR_EN
  logic miss_acc;
  assign miss_acc = (push || rd_acc) && (req_kind == K_MISS);

  // Miss capture; a fresh miss beats a same-edge clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (loc_wr && head.off[3:2] == R_ERR) err <= 1'b0;
      if (miss_acc) begin
        err      <= 1'b1;
        err_addr <= PrAddr;
      end
    end
`else
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

  // Interrupt lines straight from registers
  always_comb begin
    HWInt           = '0;
    HWInt[NDEV-1:0] = pend & mask[NDEV-1:0];
    HWInt[5]        = err;
  end
endmodule
